// File: rtl/div_clk_monitor.sv
// -----------------------------------------------------------------------------
// div_clk_monitor
//
// Watches the divided clock produced by the clock-divider stage. The divided
// clock arrives as an ordinary flop output in the sys_clk domain, so it is
// sampled as data (no synchronizer). The monitor does the following:
//   - emits single-cycle rise/fall strobes that downstream logic uses as
//     clock enables
//   - measures every completed high/low phase in sys_clk cycles
//   - runs a lock state machine (IDLE -> ACQ -> LOCKED) that declares the
//     divided clock good after LOCK_CNT consecutive in-tolerance phases
//   - flags out-of-tolerance phases and stalls while locked
//
// Parameters:
//   HALF_PERIOD : expected phase length in sys_clk cycles
//   TOL         : accepted deviation, good when |len - HALF_PERIOD| <= TOL
//   LOCK_CNT    : consecutive good phases needed to lock
//   STALL_LIMIT : run length without an edge treated as a stopped clock
//                 (must exceed HALF_PERIOD+TOL and be below 2**CNT_W-1)
//   CNT_W       : width of the run counter and of half_len
//
// Ports:
//   sys_clk      in   system clock, single clock domain
//   sys_rst      in   synchronous active-high reset
//   clk_in       in   divided clock, synchronous to sys_clk
//   clr          in   synchronous clear of err_cnt (wins over an increment)
//   rise_pulse   out  one-cycle strobe per rising edge of clk_in
//   fall_pulse   out  one-cycle strobe per falling edge of clk_in
//   half_len     out  length of the most recently completed phase
//   half_len_vld out  one-cycle strobe: half_len holds a new measurement
//   locked       out  high while the lock FSM is in LOCKED
//   err          out  one-cycle strobe on a fault detected while LOCKED
//   err_cnt      out  saturating fault counter
//
// All outputs are registered and change at the sys_clk edge that closes the
// cycle in which clk_in differs from its registered copy (1-cycle latency).
// -----------------------------------------------------------------------------
module div_clk_monitor #(
  parameter int unsigned HALF_PERIOD = 3,
  parameter int unsigned TOL         = 0,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned STALL_LIMIT = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             clk_in,
  input  logic             clr,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_len,
  output logic             half_len_vld,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_cnt
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int unsigned GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;

  // Tolerance window bounds, clamped so a TOL larger than HALF_PERIOD does
  // not wrap the lower bound.
  localparam int unsigned LEN_LO = (HALF_PERIOD > TOL) ? (HALF_PERIOD - TOL) : 0;
  localparam int unsigned LEN_HI = HALF_PERIOD + TOL;

  localparam logic [CNT_W-1:0]  RUN_MAX     = '1;
  localparam logic [CNT_W-1:0]  RUN_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  STALL_VAL   = CNT_W'(STALL_LIMIT);
  localparam logic [GOOD_W-1:0] LOCK_LAST   = GOOD_W'(LOCK_CNT - 1);
  localparam logic [7:0]        ERR_CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q,        state_d;
  logic              clk_d_q;
  logic [CNT_W-1:0]  run_cnt_q,      run_cnt_d;
  logic [GOOD_W-1:0] good_cnt_q,     good_cnt_d;
  logic              rise_q,         rise_d;
  logic              fall_q,         fall_d;
  logic [CNT_W-1:0]  half_len_q,     half_len_d;
  logic              half_len_vld_q, half_len_vld_d;
  logic              err_q,          err_d;
  logic [7:0]        err_cnt_q,      err_cnt_d;

  // ---------------------------------------------------------------------------
  // Edge detection and phase measurement
  // ---------------------------------------------------------------------------
  logic edge_c;
  logic stall_c;
  logic phase_good_c;

  assign edge_c = clk_in ^ clk_d_q;
  assign rise_d = edge_c & clk_in;
  assign fall_d = edge_c & ~clk_in;

  // On an edge cycle the pre-update run counter is the length of the phase
  // that just ended: it counts the cycles clk_in held its previous value.
  assign phase_good_c = (32'(run_cnt_q) >= LEN_LO) && (32'(run_cnt_q) <= LEN_HI);

  // An edge reloads the counter, so an edge and a stall never coincide.
  assign stall_c = ~edge_c && (run_cnt_q == STALL_VAL);

  always_comb begin
    if (edge_c) begin
      run_cnt_d = RUN_ONE;
    end else if (run_cnt_q == RUN_MAX) begin
      run_cnt_d = run_cnt_q;
    end else begin
      run_cnt_d = run_cnt_q + RUN_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock state machine: next state and registered-output next values
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d        = state_q;
    good_cnt_d     = good_cnt_q;
    half_len_d     = half_len_q;
    half_len_vld_d = 1'b0;
    err_d          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The first edge after idle ends a phase of unknown start, so its
        // measurement is discarded.
        if (edge_c) begin
          state_d    = ST_ACQ;
          good_cnt_d = '0;
        end
      end

      ST_ACQ: begin
        if (edge_c) begin
          half_len_d     = run_cnt_q;
          half_len_vld_d = 1'b1;
          if (phase_good_c) begin
            if (good_cnt_q == LOCK_LAST) begin
              state_d    = ST_LOCKED;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + GOOD_W'(1);
            end
          end else begin
            // Faults during acquisition only restart the run; no err strobe.
            good_cnt_d = '0;
          end
        end else if (stall_c) begin
          state_d    = ST_IDLE;
          good_cnt_d = '0;
        end
      end

      ST_LOCKED: begin
        if (edge_c) begin
          half_len_d     = run_cnt_q;
          half_len_vld_d = 1'b1;
          if (!phase_good_c) begin
            err_d      = 1'b1;
            state_d    = ST_ACQ;
            good_cnt_d = '0;
          end
        end else if (stall_c) begin
          err_d      = 1'b1;
          state_d    = ST_IDLE;
          good_cnt_d = '0;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        good_cnt_d = '0;
      end
    endcase
  end

  // Fault counter: clear has priority over a same-cycle increment.
  always_comb begin
    if (clr) begin
      err_cnt_d = '0;
    end else if (err_d && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= ST_IDLE;
      clk_d_q        <= 1'b0;
      run_cnt_q      <= '0;
      good_cnt_q     <= '0;
      rise_q         <= 1'b0;
      fall_q         <= 1'b0;
      half_len_q     <= '0;
      half_len_vld_q <= 1'b0;
      err_q          <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      clk_d_q        <= clk_in;
      run_cnt_q      <= run_cnt_d;
      good_cnt_q     <= good_cnt_d;
      rise_q         <= rise_d;
      fall_q         <= fall_d;
      half_len_q     <= half_len_d;
      half_len_vld_q <= half_len_vld_d;
      err_q          <= err_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign half_len     = half_len_q;
  assign half_len_vld = half_len_vld_q;
  assign err          = err_q;
  assign err_cnt      = err_cnt_q;
  // Decoded straight from the state flop, so it carries no extra latency.
  assign locked       = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_div_clk_monitor.sv
// -----------------------------------------------------------------------------
// tb_div_clk_monitor
//
// Directed bench for div_clk_monitor. Two instances share clock and reset:
// dut uses the default parameters, dut_t uses TOL=1. Inputs change 1 ns after
// the rising edge of sys_clk; outputs are read at the same point, so a value
// read after a step reflects the cycle that edge closed.
// -----------------------------------------------------------------------------
module tb_div_clk_monitor;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       clr;
  logic       clk_in;
  logic       clk_in_t;

  logic       rise_pulse,   fall_pulse,   half_len_vld,   locked,   err;
  logic [7:0] half_len,     err_cnt;
  logic       rise_pulse_t, fall_pulse_t, half_len_vld_t, locked_t, err_t;
  logic [7:0] half_len_t,   err_cnt_t;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  div_clk_monitor dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .clk_in       (clk_in),
    .clr          (clr),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .half_len     (half_len),
    .half_len_vld (half_len_vld),
    .locked       (locked),
    .err          (err),
    .err_cnt      (err_cnt)
  );

  div_clk_monitor #(.TOL(1)) dut_t (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .clk_in       (clk_in_t),
    .clr          (clr),
    .rise_pulse   (rise_pulse_t),
    .fall_pulse   (fall_pulse_t),
    .half_len     (half_len_t),
    .half_len_vld (half_len_vld_t),
    .locked       (locked_t),
    .err          (err_t),
    .err_cnt      (err_cnt_t)
  );

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no checking)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst  = 1'b1;
    clr      = 1'b0;
    clk_in   = 1'b0;
    clk_in_t = 1'b0;
    step();
    sys_rst  = 1'b0;
  endtask

  // Toggle the main clk_in and hold the new level for n cycles.
  task automatic toggle_hold(input int n);
    clk_in = ~clk_in;
    repeat (n) step();
  endtask

  // ---------------------------------------------------------------------------
  // Reset values
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    total++; if (rise_pulse !== 1'b0)   begin bad++; $display("FAIL rst_rise: got %0b want 0", rise_pulse); end
    total++; if (fall_pulse !== 1'b0)   begin bad++; $display("FAIL rst_fall: got %0b want 0", fall_pulse); end
    total++; if (half_len !== 8'd0)     begin bad++; $display("FAIL rst_half_len: got %0d want 0", half_len); end
    total++; if (half_len_vld !== 1'b0) begin bad++; $display("FAIL rst_vld: got %0b want 0", half_len_vld); end
    total++; if (locked !== 1'b0)       begin bad++; $display("FAIL rst_locked: got %0b want 0", locked); end
    total++; if (err !== 1'b0)          begin bad++; $display("FAIL rst_err: got %0b want 0", err); end
    total++; if (err_cnt !== 8'd0)      begin bad++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
    total++; if (locked_t !== 1'b0)     begin bad++; $display("FAIL rst_locked_t: got %0b want 0", locked_t); end
  endtask

  // ---------------------------------------------------------------------------
  // TOL=1: phases of 2 and 4 stay locked, a phase of 5 is a fault
  // ---------------------------------------------------------------------------
  task automatic test_tol();
    int hold    [8] = '{3, 3, 3, 3, 2, 4, 5, 1};
    int exp_len [8] = '{0, 3, 3, 3, 3, 2, 4, 5};
    bit exp_lk  [8] = '{0, 0, 0, 0, 1, 1, 1, 0};
    bit exp_err [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    for (int e = 0; e < 8; e++) begin
      clk_in_t = ~clk_in_t;
      step();
      total++; if (rise_pulse_t !== clk_in_t)  begin bad++; $display("FAIL tol_rise e%0d: got %0b want %0b", e + 1, rise_pulse_t, clk_in_t); end
      total++; if (half_len_vld_t !== (e > 0)) begin bad++; $display("FAIL tol_vld e%0d: got %0b want %0b", e + 1, half_len_vld_t, (e > 0)); end
      total++; if (half_len_t !== 8'(exp_len[e])) begin bad++; $display("FAIL tol_len e%0d: got %0d want %0d", e + 1, half_len_t, exp_len[e]); end
      total++; if (locked_t !== exp_lk[e])     begin bad++; $display("FAIL tol_locked e%0d: got %0b want %0b", e + 1, locked_t, exp_lk[e]); end
      total++; if (err_t !== exp_err[e])       begin bad++; $display("FAIL tol_err e%0d: got %0b want %0b", e + 1, err_t, exp_err[e]); end
      total++; if (err_cnt_t !== 8'(exp_err[e])) begin bad++; $display("FAIL tol_err_cnt e%0d: got %0d want %0d", e + 1, err_cnt_t, exp_err[e]); end
      for (int k = 1; k < hold[e]; k++) step();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Acquisition, lock at edge 5, one 4-cycle fault, relock after 4 phases
  // ---------------------------------------------------------------------------
  task automatic test_lock();
    int hold    [10] = '{3, 3, 3, 3, 4, 3, 3, 3, 3, 1};
    int exp_len [10] = '{0, 3, 3, 3, 3, 4, 3, 3, 3, 3};
    bit exp_lk  [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bit exp_err [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    int exp_cnt [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    do_reset();
    repeat (10) step();
    total++; if (rise_pulse !== 1'b0) begin bad++; $display("FAIL quiet_rise: got %0b want 0", rise_pulse); end
    total++; if (locked !== 1'b0)     begin bad++; $display("FAIL quiet_locked: got %0b want 0", locked); end
    for (int e = 0; e < 10; e++) begin
      clk_in = ~clk_in;
      step();
      total++; if (rise_pulse !== clk_in)    begin bad++; $display("FAIL lock_rise e%0d: got %0b want %0b", e + 1, rise_pulse, clk_in); end
      total++; if (fall_pulse !== ~clk_in)   begin bad++; $display("FAIL lock_fall e%0d: got %0b want %0b", e + 1, fall_pulse, ~clk_in); end
      total++; if (half_len_vld !== (e > 0)) begin bad++; $display("FAIL lock_vld e%0d: got %0b want %0b", e + 1, half_len_vld, (e > 0)); end
      total++; if (half_len !== 8'(exp_len[e])) begin bad++; $display("FAIL lock_len e%0d: got %0d want %0d", e + 1, half_len, exp_len[e]); end
      total++; if (locked !== exp_lk[e])     begin bad++; $display("FAIL lock_locked e%0d: got %0b want %0b", e + 1, locked, exp_lk[e]); end
      total++; if (err !== exp_err[e])       begin bad++; $display("FAIL lock_err e%0d: got %0b want %0b", e + 1, err, exp_err[e]); end
      total++; if (err_cnt !== 8'(exp_cnt[e])) begin bad++; $display("FAIL lock_err_cnt e%0d: got %0d want %0d", e + 1, err_cnt, exp_cnt[e]); end
      for (int k = 1; k < hold[e]; k++) begin
        step();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL lock_err_hold e%0d: got %0b want 0", e + 1, err); end
        total++; if ((rise_pulse | fall_pulse) !== 1'b0) begin bad++; $display("FAIL lock_strobe_hold e%0d: got %0b want 0", e + 1, rise_pulse | fall_pulse); end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stall while locked (clk_in held low), then resume and relock
  // ---------------------------------------------------------------------------
  task automatic test_stall();
    // The falling edge that locked was already stepped once.
    for (int i = 2; i <= 8; i++) begin
      step();
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL stall_pre_locked c%0d: got %0b want 1", i, locked); end
      total++; if (err !== 1'b0)    begin bad++; $display("FAIL stall_pre_err c%0d: got %0b want 0", i, err); end
    end
    step();
    total++; if (err !== 1'b1)      begin bad++; $display("FAIL stall_err: got %0b want 1", err); end
    total++; if (locked !== 1'b0)   begin bad++; $display("FAIL stall_locked: got %0b want 0", locked); end
    total++; if (err_cnt !== 8'd2)  begin bad++; $display("FAIL stall_err_cnt: got %0d want 2", err_cnt); end
    step();
    total++; if (err !== 1'b0)      begin bad++; $display("FAIL stall_err_once: got %0b want 0", err); end

    clk_in = 1'b1;
    step();
    total++; if (rise_pulse !== 1'b1)   begin bad++; $display("FAIL resume_rise: got %0b want 1", rise_pulse); end
    total++; if (half_len_vld !== 1'b0) begin bad++; $display("FAIL resume_vld: got %0b want 0", half_len_vld); end
    for (int e = 2; e <= 5; e++) begin
      repeat (2) step();
      clk_in = ~clk_in;
      step();
      total++; if (half_len_vld !== 1'b1) begin bad++; $display("FAIL relock_vld e%0d: got %0b want 1", e, half_len_vld); end
      total++; if (half_len !== 8'd3)     begin bad++; $display("FAIL relock_len e%0d: got %0d want 3", e, half_len); end
      total++; if (locked !== (e == 5))   begin bad++; $display("FAIL relock_locked e%0d: got %0b want %0b", e, locked, (e == 5)); end
    end
  endtask

  // ---------------------------------------------------------------------------
  // 260 further faults saturate err_cnt; clr beats a same-cycle increment
  // ---------------------------------------------------------------------------
  task automatic test_saturate();
    // Locked on a rising edge, one cycle into the high phase: stretch it to 4.
    repeat (3) step();
    for (int i = 0; i < 260; i++) begin
      toggle_hold(3);  // closes a 4-cycle phase: fault
      toggle_hold(3);
      toggle_hold(3);
      toggle_hold(3);
      toggle_hold(4);  // fourth good phase: locked, and this phase is 4 long
    end
    total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL sat_err_cnt: got %0d want 255", err_cnt); end
    total++; if (locked !== 1'b1)    begin bad++; $display("FAIL sat_locked: got %0b want 1", locked); end

    clk_in = ~clk_in;
    clr    = 1'b1;
    step();
    clr    = 1'b0;
    total++; if (err !== 1'b1)      begin bad++; $display("FAIL clr_err: got %0b want 1", err); end
    total++; if (err_cnt !== 8'd0)  begin bad++; $display("FAIL clr_err_cnt: got %0d want 0", err_cnt); end
    total++; if (locked !== 1'b0)   begin bad++; $display("FAIL clr_locked: got %0b want 0", locked); end
    step();
    total++; if (err !== 1'b0)      begin bad++; $display("FAIL clr_err_once: got %0b want 0", err); end
    total++; if (err_cnt !== 8'd0)  begin bad++; $display("FAIL clr_err_cnt_hold: got %0d want 0", err_cnt); end
  endtask

  // ---------------------------------------------------------------------------
  // Reset while locked with err_cnt=3
  // ---------------------------------------------------------------------------
  task automatic test_rst_locked();
    // Current phase has 2 cycles so far; make it 3.
    step();
    for (int i = 0; i < 3; i++) begin
      toggle_hold(3);
      toggle_hold(3);
      toggle_hold(3);
      toggle_hold(4);  // locked; this phase is 4 long
      toggle_hold(3);  // fault
    end
    toggle_hold(3);
    toggle_hold(3);
    toggle_hold(3);
    clk_in = ~clk_in;
    step();
    total++; if (locked !== 1'b1)   begin bad++; $display("FAIL prerst_locked: got %0b want 1", locked); end
    total++; if (err_cnt !== 8'd3)  begin bad++; $display("FAIL prerst_err_cnt: got %0d want 3", err_cnt); end
    step();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    total++; if (locked !== 1'b0)       begin bad++; $display("FAIL lrst_locked: got %0b want 0", locked); end
    total++; if (err_cnt !== 8'd0)      begin bad++; $display("FAIL lrst_err_cnt: got %0d want 0", err_cnt); end
    total++; if (half_len !== 8'd0)     begin bad++; $display("FAIL lrst_half_len: got %0d want 0", half_len); end
    total++; if ((rise_pulse | fall_pulse | half_len_vld | err) !== 1'b0) begin
      bad++; $display("FAIL lrst_strobes: got %0b want 0", rise_pulse | fall_pulse | half_len_vld | err);
    end
  endtask

  initial begin
    test_reset();
    test_tol();
    test_lock();
    test_stall();
    test_saturate();
    test_rst_locked();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
